// File: rtl/pri_icache_ctrl_responder.sv
// pri_icache_ctrl_responder
//   Bank-side responder for the private L1 icache control bus. It accepts
//   bypass, flush and selective-flush requests from the icache control unit
//   and returns level acks. It sequences the L1 tag array: it drains
//   in-flight fetches, walks sets to invalidate, performs the tag lookup for
//   a selective flush, and switches the cache into and out of bypass.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   bypass_req_i/_ack_o    level bypass request; the ack mirrors bypass state
//   flush_req_i/_ack_o     full-flush request / done
//   sel_flush_req_i/_ack_o selective-flush request / done
//   sel_flush_addr_i       byte address of the line to invalidate
//   fetch_busy_i           a refill or fetch is outstanding
//   fetch_stall_o          blocks new fetch acceptance
//   bypass_en_o            routes fetches around the arrays
//   tag_req_o/_we_o        tag-array strobe; a write always clears valid
//   tag_addr_o             set index
//   tag_way_mask_o         ways to write
//   tag_valid_i/_rdata_i   read data, one cycle after a read strobe
//
// Optional feature (macro ICACHE_CTRL_STAT_EN): four saturating 32-bit event
//   counters (hit, miss, trans, cong) with clear_regs_i / enable_regs_i.
module pri_icache_ctrl_responder #(
  parameter int NB_WAYS    = 4,
  parameter int NB_SETS    = 32,
  parameter int LINE_BYTES = 16,
  parameter int SET_W      = $clog2(NB_SETS),
  parameter int OFF_W      = $clog2(LINE_BYTES),
  parameter int TAG_W      = 32 - SET_W - OFF_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
`ifdef ICACHE_CTRL_STAT_EN
  input  logic                     hit_i,
  input  logic                     miss_i,
  input  logic                     trans_i,
  input  logic                     cong_i,
  input  logic                     clear_regs_i,
  input  logic                     enable_regs_i,
  output logic [31:0]              ctrl_hit_count_o,
  output logic [31:0]              ctrl_miss_count_o,
  output logic [31:0]              ctrl_trans_count_o,
  output logic [31:0]              ctrl_cong_count_o,
`endif
  input  logic                     bypass_req_i,
  output logic                     bypass_ack_o,
  input  logic                     flush_req_i,
  output logic                     flush_ack_o,
  input  logic                     sel_flush_req_i,
  input  logic [31:0]              sel_flush_addr_i,
  output logic                     sel_flush_ack_o,
  input  logic                     fetch_busy_i,
  output logic                     fetch_stall_o,
  output logic                     bypass_en_o,
  output logic                     tag_req_o,
  output logic                     tag_we_o,
  output logic [SET_W-1:0]         tag_addr_o,
  output logic [NB_WAYS-1:0]       tag_way_mask_o,
  input  logic [NB_WAYS-1:0]       tag_valid_i,
  input  logic [NB_WAYS*TAG_W-1:0] tag_rdata_i
);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_DRAIN, ST_FLUSH, ST_SEL_RD, ST_SEL_CMP, ST_ACK
  } state_t;

  typedef enum logic [1:0] {OP_FLUSH, OP_SEL, OP_BYP} op_t;

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NB_SETS - 1);
  localparam int LADDR_W = 32 - OFF_W;

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [SET_W-1:0]   cnt_q, cnt_d;
  logic               bypass_q, bypass_d;
  logic [LADDR_W-1:0] addr_q, addr_d;      // line address (offset dropped)

  logic [NB_WAYS-1:0] match;
  logic               flush_ack, sel_ack, ack_req;

  // The byte offset within a line is irrelevant to invalidation.
  logic unused_addr_bits;
  assign unused_addr_bits = ^sel_flush_addr_i[OFF_W-1:0];

  // Per-way hit vector against the latched selective-flush tag.
  for (genvar gi = 0; gi < NB_WAYS; gi++) begin : g_cmp
    assign match[gi] = tag_valid_i[gi] &&
                       (tag_rdata_i[gi*TAG_W +: TAG_W] == addr_q[LADDR_W-1 -: TAG_W]);
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    cnt_d          = cnt_q;
    bypass_d       = bypass_q;
    addr_d         = addr_q;
    fetch_stall_o  = 1'b1;
    tag_req_o      = 1'b0;
    tag_we_o       = 1'b0;
    tag_addr_o     = '0;
    tag_way_mask_o = '0;
    flush_ack      = 1'b0;
    sel_ack        = 1'b0;
    ack_req        = 1'b0;

    case (state_q)
      // INIT and FLUSH share the all-ways invalidate walk.
      ST_INIT, ST_FLUSH: begin
        tag_req_o      = 1'b1;
        tag_we_o       = 1'b1;
        tag_addr_o     = cnt_q;
        tag_way_mask_o = '1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LAST_SET) begin
          cnt_d   = '0;
          state_d = (state_q == ST_INIT) ? ST_IDLE : ST_ACK;
        end
      end
      ST_IDLE: begin
        fetch_stall_o = 1'b0;
        addr_d        = sel_flush_addr_i[31:OFF_W];
        if (flush_req_i) begin
          op_d    = OP_FLUSH;
          state_d = ST_DRAIN;
        end else if (sel_flush_req_i && !sel_ack) begin
          op_d    = OP_SEL;
          state_d = ST_DRAIN;
        end else if (bypass_req_i != bypass_q) begin
          op_d    = OP_BYP;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!fetch_busy_i) begin
          case (op_q)
            OP_FLUSH: begin
              cnt_d   = '0;
              state_d = ST_FLUSH;
            end
            OP_SEL:  state_d = ST_SEL_RD;
            default: begin
              // Bypass flips only once the pipeline is empty.
              bypass_d = bypass_req_i;
              state_d  = ST_IDLE;
            end
          endcase
        end
      end
      ST_SEL_RD: begin
        tag_req_o  = 1'b1;
        tag_addr_o = addr_q[SET_W-1:0];
        state_d    = ST_SEL_CMP;
      end
      ST_SEL_CMP: begin
        // Every matching way is cleared in a single write.
        if (|match) begin
          tag_req_o      = 1'b1;
          tag_we_o       = 1'b1;
          tag_addr_o     = addr_q[SET_W-1:0];
          tag_way_mask_o = match;
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (op_q == OP_FLUSH) begin
          flush_ack = 1'b1;
          ack_req   = flush_req_i;
        end else begin
          sel_ack   = 1'b1;
          ack_req   = sel_flush_req_i;
        end
        if (!ack_req) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    // Outputs sit at their idle-safe values while reset is held.
    if (rst_i) begin
      fetch_stall_o = 1'b1;
      tag_req_o     = 1'b0;
      tag_we_o      = 1'b0;
      flush_ack     = 1'b0;
      sel_ack       = 1'b0;
    end
  end

  assign flush_ack_o     = flush_ack;
  assign sel_flush_ack_o = sel_ack;
  assign bypass_en_o     = bypass_q & ~rst_i;
  assign bypass_ack_o    = bypass_q & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_INIT;
      op_q     <= OP_FLUSH;
      cnt_q    <= '0;
      bypass_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      bypass_q <= bypass_d;
      addr_q   <= addr_d;
    end
  end

`ifdef ICACHE_CTRL_STAT_EN
  logic [3:0]  stat_ev;
  logic [31:0] stat_cnt [4];

  assign stat_ev = {cong_i, trans_i, miss_i, hit_i};

  for (genvar gi = 0; gi < 4; gi++) begin : g_stat
    logic [31:0] cnt_stat_q, cnt_stat_d;

    // Clear wins over a coincident increment; counters stick at all-ones.
    always_comb begin
      cnt_stat_d = cnt_stat_q;
      if (clear_regs_i)
        cnt_stat_d = '0;
      else if (enable_regs_i && stat_ev[gi] && (cnt_stat_q != 32'hFFFF_FFFF))
        cnt_stat_d = cnt_stat_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) cnt_stat_q <= '0;
      else       cnt_stat_q <= cnt_stat_d;
    end

    assign stat_cnt[gi] = cnt_stat_q;
  end

  assign ctrl_hit_count_o   = stat_cnt[0];
  assign ctrl_miss_count_o  = stat_cnt[1];
  assign ctrl_trans_count_o = stat_cnt[2];
  assign ctrl_cong_count_o  = stat_cnt[3];
`endif

endmodule
